// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Keeps at most one instruction-memory
//               read outstanding, buffers returned words with their pc+4 in a
//               2-entry FIFO and presents the head entry to decode. A flush
//               redirects fetch and drops buffered and in-flight data.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        id_we,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_next,
    output logic        valid
);

    localparam logic [1:0]  c_FIFO_FULL = 2'd2;
    localparam logic [31:0] c_PC_STEP   = 32'd4;

    // IDLE: no request; BUSY: request whose data is kept;
    // DISCARD: request still in flight whose data must be thrown away.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_BUSY    = 2'b01,
        S_DISCARD = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_addr;
    logic [1:0]  r_count;
    logic [31:0] r_fifo_instr [0:1];
    logic [31:0] r_fifo_pcn   [0:1];

    logic        w_req;
    logic        w_ack;
    logic        w_valid;
    logic        w_push;
    logic        w_pop;
    logic        w_new_req;
    logic        w_wr_slot;
    logic [1:0]  w_count_after_pop;
    logic [1:0]  w_count_next;
    logic [31:0] w_fetch_pc_next;
    logic [31:0] w_flush_target;
    logic [1:0]  w_unused_flush_lsb;

    // The low two bits of the redirect target are architecturally ignored.
    assign w_unused_flush_lsb = flush_pc[1:0];
    assign w_flush_target     = {flush_pc[31:2], 2'b00};

    // A request is outstanding in both BUSY and DISCARD; acks are only
    // meaningful while a request is outstanding.
    assign w_req   = (r_state != S_IDLE);
    assign w_ack   = w_req & imem_ack;
    assign w_valid = (r_count != 2'd0);

    // Flush wins over both FIFO operations in the same cycle.
    assign w_push = w_ack & (r_state == S_BUSY) & ~flush;
    assign w_pop  = id_we & w_valid & ~flush;

    // A push lands in the first free slot after any simultaneous pop has
    // shifted the FIFO. Pushes only occur with fewer than two entries.
    assign w_count_after_pop = r_count - {1'b0, w_pop};
    assign w_wr_slot         = w_count_after_pop[0];

    // Redirect target on flush, otherwise advance past each kept word.
    assign w_fetch_pc_next = flush  ? w_flush_target :
                             w_push ? (r_fetch_pc + c_PC_STEP) :
                                      r_fetch_pc;

    // End-of-cycle FIFO occupancy, used by the request-issue decision.
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + 2'd1;
                2'b01:   w_count_next = r_count - 2'd1;
                default: w_count_next = r_count;
            endcase
        end
    end

    // Next-state decode; w_new_req marks cycles that launch a fresh request.
    always_comb begin
        w_state_next = r_state;
        w_new_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_count_next < c_FIFO_FULL) begin
                    w_state_next = S_BUSY;
                    w_new_req    = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_ack) begin
                    if (w_count_next < c_FIFO_FULL) begin
                        w_state_next = S_BUSY;
                        w_new_req    = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (flush) begin
                    w_state_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (w_ack) begin
                    if (w_count_next < c_FIFO_FULL) begin
                        w_state_next = S_BUSY;
                        w_new_req    = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch pointer and the address of the request currently on the bus;
    // a new request always targets the updated fetch pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= 32'h0000_0000;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            if (w_new_req) begin
                r_req_addr <= w_fetch_pc_next;
            end
        end
    end

    // FIFO occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // FIFO storage: entry 0 is the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_instr[0] <= 32'h0000_0000;
            r_fifo_instr[1] <= 32'h0000_0000;
            r_fifo_pcn[0]   <= 32'h0000_0000;
            r_fifo_pcn[1]   <= 32'h0000_0000;
        end else begin
            if (w_pop) begin
                r_fifo_instr[0] <= r_fifo_instr[1];
                r_fifo_pcn[0]   <= r_fifo_pcn[1];
            end
            if (w_push) begin
                r_fifo_instr[w_wr_slot] <= imem_rdata;
                r_fifo_pcn[w_wr_slot]   <= r_req_addr + c_PC_STEP;
            end
        end
    end

    // Outputs: empty FIFO presents a NOP with zero pc_next.
    assign imem_req    = w_req;
    assign imem_addr   = w_req   ? r_req_addr      : 32'h0000_0000;
    assign valid       = w_valid;
    assign instruction = w_valid ? r_fifo_instr[0] : 32'h0000_0000;
    assign pc_next     = w_valid ? r_fifo_pcn[0]   : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. Directed scenarios plus
//               randomized memory latency / flush / decode-stall traffic,
//               compared each cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] P_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_we;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_next;
    logic        valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: buffered {instruction, pc_next} entries in order,
    // the single outstanding request (if any) and whether its data is dropped.
    logic [63:0] m_q [$];
    bit          m_req;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    int          m_age;

    if_stage #(.RESET_PC(P_RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .id_we       (id_we),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_next     (pc_next),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_update(input bit rst_i, input bit fl_i, input logic [31:0] fpc_i,
                                input bit we_i, input bit ack_i, input logic [31:0] rdata_i);
        bit acked;
        if (rst_i) begin
            m_q.delete();
            m_req  = 1'b0;
            m_drop = 1'b0;
            m_pc   = P_RESET_PC;
            m_addr = 32'h0;
            m_age  = 0;
            return;
        end
        acked = m_req && ack_i;
        if (fl_i) begin
            m_q.delete();
            m_pc = {fpc_i[31:2], 2'b00};
        end else begin
            if (we_i && m_q.size() > 0) void'(m_q.pop_front());
            if (acked && !m_drop) begin
                m_q.push_back({rdata_i, m_addr + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
        if (m_req && !acked) begin
            if (fl_i) m_drop = 1'b1;
            m_age++;
        end else if (m_q.size() < 2) begin
            m_req  = 1'b1;
            m_addr = m_pc;
            m_drop = 1'b0;
            m_age  = 0;
        end else begin
            m_req = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_instr;
        logic [31:0] e_pcn;
        e_instr = 32'h0;
        e_pcn   = 32'h0;
        if (m_q.size() > 0) {e_instr, e_pcn} = m_q[0];
        check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) check("imem_addr", imem_addr, m_addr);
        check("valid", {31'd0, valid}, {31'd0, (m_q.size() > 0)});
        check("instruction", instruction, e_instr);
        check("pc_next", pc_next, e_pcn);
    endtask

    // Drive one cycle of inputs (called at a falling edge), clock it, check.
    task automatic step(input bit rst_i, input bit fl_i, input logic [31:0] fpc_i,
                        input bit we_i, input bit ack_i);
        logic [31:0] rd;
        rd = m_req ? mem_word(m_addr) : $urandom;
        reset      = rst_i;
        flush      = fl_i;
        flush_pc   = fpc_i;
        id_we      = we_i;
        imem_ack   = ack_i;
        imem_rdata = rd;
        model_update(rst_i, fl_i, fpc_i, we_i, ack_i, rd);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // lat = 0: random ack; lat = N: ack in the Nth cycle of each request.
    // Acks are also sprinkled randomly while no request is outstanding.
    task automatic run_random(input int n, input int lat, input int fl_pct,
                              input int we_pct, input int rst_pm);
        for (int i = 0; i < n; i++) begin
            bit          a;
            bit          f;
            bit          w;
            bit          r;
            logic [31:0] fp;
            if (m_req) a = (lat == 0) ? ($urandom_range(0, 1) == 1) : (m_age >= lat - 1);
            else       a = ($urandom_range(0, 1) == 1);
            f  = ($urandom_range(0, 99) < fl_pct);
            w  = ($urandom_range(0, 99) < we_pct);
            r  = ($urandom_range(0, 999) < rst_pm);
            fp = $urandom;
            if ($urandom_range(0, 3) == 0) fp = 32'hFFFF_FFF0 | (fp & 32'hF);
            step(r, f, fp, w, a);
        end
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        id_we      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);

        // Reset state; reset also overrides flush and id_we.
        step(1, 0, 32'h0, 0, 0);
        step(1, 1, 32'h40, 1, 1);
        check("reset_addr", imem_addr, 32'h0);

        // Zero-wait streaming from RESET_PC.
        step(0, 0, 32'h0, 1, 1);
        check("c1_addr", imem_addr, 32'h100);
        check("c1_valid", {31'd0, valid}, 32'd0);
        step(0, 0, 32'h0, 1, 1);
        check("c2_addr", imem_addr, 32'h104);
        check("c2_pcn", pc_next, 32'h104);
        check("c2_instr", instruction, mem_word(32'h100));
        step(0, 0, 32'h0, 1, 1);
        check("c3_addr", imem_addr, 32'h108);
        check("c3_pcn", pc_next, 32'h108);
        run_random(20, 1, 0, 100, 0);

        // Decode stall for 5 cycles: FIFO fills and requests stop.
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, m_req);
        check("stall_req", {31'd0, imem_req}, 32'd0);
        check("stall_valid", {31'd0, valid}, 32'd1);
        run_random(12, 1, 0, 100, 0);

        // 3-cycle latency, flush to 0x2000 in the request's second cycle.
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 1, 32'h2000, 0, 0);
        check("disc_addr", imem_addr, 32'h100);
        step(0, 0, 32'h0, 0, 1);
        check("disc_next_addr", imem_addr, 32'h2000);
        check("disc_valid", {31'd0, valid}, 32'd0);
        step(0, 0, 32'h0, 0, 1);
        check("disc_pcn", pc_next, 32'h2004);
        check("disc_instr", instruction, mem_word(32'h2000));

        // Flush coinciding with ack while one entry is buffered.
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 1);
        check("fa_valid_before", {31'd0, valid}, 32'd1);
        step(0, 1, 32'h3003, 0, 1);
        check("fa_valid", {31'd0, valid}, 32'd0);
        check("fa_addr", imem_addr, 32'h3000);

        // Fetch address wrap at the top of the address space.
        step(1, 0, 32'h0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 0, 1);
        check("wrap_pcn", pc_next, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset mid-request with a late ack.
        step(1, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 0);
        check("rmid_req", {31'd0, imem_req}, 32'd0);
        step(0, 0, 32'h0, 1, 1);
        check("rmid_valid", {31'd0, valid}, 32'd0);
        check("rmid_addr", imem_addr, P_RESET_PC);
        step(0, 0, 32'h0, 1, 0);

        // Randomized traffic.
        run_random(300, 0, 5, 60, 5);
        run_random(200, 3, 8, 50, 0);
        run_random(200, 1, 3, 80, 2);
        run_random(100, 2, 10, 30, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  redirect fetch to flush_pc; discards all buffered and in-flight instructions.
REQ-005 flush_pc  input  32  redirect target; bits [1:0] ignored (treated as 00).
REQ-006 id_we  input  1  decode stage latches instruction/pc_next this cycle.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word-aligned read address.
REQ-009 imem_ack  input  1  read completes this cycle; imem_rdata valid.
REQ-010 imem_rdata  input  32  read data.
REQ-011 instruction  output  32  head-of-buffer instruction to decode.
REQ-012 pc_next  output  32  address of that instruction plus 4.
REQ-013 valid  output  1  instruction/pc_next hold a real fetched instruction.

Function
REQ-014 Internal fetch_pc (32 b) SHALL hold the address of the next request; it increments by 4 on every accepted ack, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-015 A 2-entry FIFO SHALL hold {instruction, pc_next} pairs; pc_next = request address + 4 (mod 2^32).
REQ-016 FSM states: IDLE (no request), BUSY (request outstanding), DISCARD (outstanding request whose data is dropped).
REQ-017 imem_req SHALL be 1 exactly in BUSY and DISCARD; imem_addr SHALL equal the outstanding request address and stay stable until ack.
REQ-018 imem_ack SHALL be ignored in any cycle with imem_req = 0.
REQ-019 IDLE -> BUSY when end-of-cycle FIFO occupancy < 2; request address = fetch_pc.
REQ-020 BUSY with ack: push entry, fetch_pc += 4; stay BUSY (next address issued following cycle) if end-of-cycle occupancy < 2, else IDLE.
REQ-021 BUSY without ack: hold.
REQ-022 Pop SHALL occur when id_we = 1 and valid = 1; id_we with valid = 0 has no effect.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order; overflow is impossible since at most one request is outstanding and requests issue only with occupancy < 2.
REQ-024 valid = (occupancy > 0); when empty, instruction = 32'h0000_0000 (NOP) and pc_next = 0.
REQ-025 flush SHALL empty the FIFO and set fetch_pc = {flush_pc[31:2], 2'b00} on the same edge; flush overrides push/pop that cycle.
REQ-026 flush in BUSY without ack -> DISCARD; with ack -> data dropped, next state BUSY at new fetch_pc.
REQ-027 DISCARD: hold old address until ack; ack data dropped, fetch_pc unchanged, -> BUSY at fetch_pc. A further flush in DISCARD only updates fetch_pc.
REQ-028 Flush in IDLE -> BUSY at new fetch_pc next cycle.
REQ-029 With zero-wait memory (ack whenever req), throughput SHALL be one instruction per cycle; first valid appears 2 cycles after reset release.

Reset
REQ-030 reset SHALL force: state IDLE, FIFO empty, fetch_pc = RESET_PC, imem_req = 0, imem_addr = 0, valid = 0, instruction = 0, pc_next = 0.
REQ-031 reset asserted mid-request SHALL abandon it; a late ack after reset is ignored per REQ-018.
REQ-032 reset SHALL override flush and id_we.

Verification
REQ-033 Zero-wait memory, id_we = 1 always, RESET_PC = 0x100: after reset release cycles 1,2,3 imem_addr = 0x100,0x104,0x108; valid from cycle 2 with pc_next 0x104, 0x108, ... one per cycle.
REQ-034 id_we = 0 for 5 cycles: FIFO fills to 2, imem_req drops, valid stays 1, instruction unchanged; id_we = 1 resumes in-order delivery, no loss or duplication.
REQ-035 3-cycle memory latency, flush to 0x2000 in request's second cycle: imem_addr held until ack, ack data never appears at output, next request at 0x2000, first valid pc_next = 0x2004.
REQ-036 flush and ack in same cycle with FIFO holding 1 entry: valid = 0 next cycle, next imem_addr = flush_pc.
REQ-037 fetch_pc = 0xFFFF_FFFC, ack: entry pc_next = 0x0000_0000, next imem_addr = 0x0000_0000.
REQ-038 reset mid-BUSY, ack one cycle later: imem_req = 0, valid = 0, entry not pushed; next request at RESET_PC.
